// File: rtl/fp_divider_seq_if.sv
// ---------------------------------------------------------------------------
// fp_divider_seq_if
// Handshake and data bundle for the sequential floating-point divider.
//   in_valid / in_ready   : operand handshake (requester -> divider)
//   a_operand / b_operand : dividend / divisor, W = 1+EXP_W+MAN_W bits
//   out_valid / out_ready : result handshake (divider -> consumer)
//   result                : quotient, W bits
//   flags                 : {invalid, div_by_zero, overflow, underflow, inexact}
//   Exception             : OR of flags[4:1]
// master = side issuing operands and consuming results; slave = divider.
// ---------------------------------------------------------------------------
interface fp_divider_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_operand;
  logic [W-1:0] b_operand;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;
  logic         Exception;

  modport master (
    output in_valid, a_operand, b_operand, out_ready,
    input  in_ready, out_valid, result, flags, Exception
  );

  modport slave (
    input  in_valid, a_operand, b_operand, out_ready,
    output in_ready, out_valid, result, flags, Exception
  );
endinterface

// File: rtl/fp_divider_seq.sv
// ---------------------------------------------------------------------------
// fp_divider_seq
// Sequential IEEE-754-style divider (a / b). Uses an exact radix-2 restoring
// mantissa recurrence (one quotient bit per cycle) followed by a single
// round-to-nearest-even step. Subnormal inputs are flushed to signed zero and
// tiny results are flushed to signed zero. One operation in flight.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : fp_divider_seq_if.slave (operand/result handshakes, flags)
// Latency from the accepting edge: 1 edge for special operands,
// MAN_W+5 edges for normal operands.
// ---------------------------------------------------------------------------
module fp_divider_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic            clk,
  input  logic            reset,
  fp_divider_seq_if.slave bus
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int N     = MAN_W + 3;
  localparam int CNT_W = $clog2(N);
  localparam int XW    = EXP_W + 2;

  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic signed [XW-1:0] BIAS     = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_TOP  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(N - 1);
  localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, CHECK, DIVIDE, ROUND, DONE} state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           a_q, a_d, b_q, b_d;
  logic                   sign_q, sign_d;
  logic signed [XW-1:0]   exp_q, exp_d;
  logic [MAN_W+1:0]       rem_q, rem_d;
  logic [MAN_W:0]         div_q, div_d;
  logic [N-1:0]           quo_q, quo_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [W-1:0]           result_q, result_d;
  logic [4:0]             flags_q, flags_d;

  logic [EXP_W-1:0]       ea, eb;
  logic [MAN_W-1:0]       fa, fb;
  logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
  logic [MAN_W:0]         rem_diff;
  logic [W+4:0]           rnd;

  function automatic logic [W-1:0] inf_of(input logic s);
    return {s, EXP_ONES, {MAN_W{1'b0}}};
  endfunction

  function automatic logic [W-1:0] zero_of(input logic s);
    return {s, {(W-1){1'b0}}};
  endfunction

  // Normalise the raw quotient, apply round-to-nearest-even and saturate the
  // exponent. Returns {flags, result}.
  function automatic logic [W+4:0] round_pack(
    input logic                 s,
    input logic [N-1:0]         q,
    input logic                 rem_nz,
    input logic signed [XW-1:0] e_in
  );
    logic [MAN_W:0]       sig;
    logic                 guard;
    logic                 sticky;
    logic                 inc;
    logic [MAN_W+1:0]     sig_r;
    logic [MAN_W-1:0]     frac;
    logic signed [XW-1:0] e;
    if (q[N-1]) begin
      sig    = q[N-1:2];
      guard  = q[1];
      sticky = q[0] | rem_nz;
      e      = e_in;
    end else begin
      // quotient below 1.0: one more bit of precision, exponent drops by one
      sig    = q[N-2:1];
      guard  = q[0];
      sticky = rem_nz;
      e      = e_in - XW'(1);
    end
    inc   = guard & (sticky | sig[0]);
    sig_r = {1'b0, sig} + {{(MAN_W+1){1'b0}}, inc};
    if (sig_r[MAN_W+1]) begin
      // rounding carried past the hidden bit: significand is 1.0 again
      frac = '0;
      e    = e + XW'(1);
    end else begin
      frac = sig_r[MAN_W-1:0];
    end
    if (e >= EXP_TOP) begin
      return {5'b00101, inf_of(s)};
    end else if (e <= EXP_ZERO) begin
      return {5'b00011, zero_of(s)};
    end
    return {4'b0000, guard | sticky, s, e[EXP_W-1:0], frac};
  endfunction

  assign ea     = a_q[W-2:MAN_W];
  assign eb     = b_q[W-2:MAN_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);
  assign sgn    = a_q[W-1] ^ b_q[W-1];

  // rem < 2*div whenever rem >= div, so the difference fits in MAN_W+1 bits
  assign rem_diff = rem_q[MAN_W:0] - div_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    rnd      = '0;
    case (state_q)
      // IDLE: capture operands on handshake
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a_operand;
          b_d     = bus.b_operand;
          state_d = CHECK;
        end
      end
      // CHECK: classify operands, resolve special cases, seed the recurrence
      CHECK: begin
        sign_d = sgn;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          result_d = QNAN;
          flags_d  = 5'b10000;
          state_d  = DONE;
        end else if (a_inf) begin
          result_d = inf_of(sgn);
          flags_d  = 5'b00000;
          state_d  = DONE;
        end else if (b_zero) begin
          result_d = inf_of(sgn);
          flags_d  = 5'b01000;
          state_d  = DONE;
        end else if (b_inf || a_zero) begin
          result_d = zero_of(sgn);
          flags_d  = 5'b00000;
          state_d  = DONE;
        end else begin
          exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
          rem_d   = {2'b01, fa};
          div_d   = {1'b1, fb};
          quo_d   = '0;
          cnt_d   = '0;
          state_d = DIVIDE;
        end
      end
      // DIVIDE: one restoring step per cycle, quotient MSB first
      DIVIDE: begin
        if (rem_q >= {1'b0, div_q}) begin
          rem_d = {rem_diff, 1'b0};
          quo_d = {quo_q[N-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[MAN_W:0], 1'b0};
          quo_d = {quo_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ROUND;
        end
      end
      // ROUND: normalise, RNE, range check
      ROUND: begin
        rnd      = round_pack(sign_q, quo_q, |rem_q, exp_q);
        result_d = rnd[W-1:0];
        flags_d  = rnd[W+4:W];
        state_d  = DONE;
      end
      // DONE: hold result until the consumer takes it
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    sign_q <= sign_d;
    exp_q  <= exp_d;
    rem_q  <= rem_d;
    div_q  <= div_d;
    quo_q  <= quo_d;
    cnt_q  <= cnt_d;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.Exception = |flags_q[4:1];

endmodule
